// File: rtl/demultiplexor_1in_3out.sv
// One-in, three-out demultiplexor with a one-entry holding register per channel.
// Words with Sel==3 are accepted and dropped; Error and DropCount record those drops.
module demultiplexor_1in_3out #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     Entrada,
    input  logic [1:0]           Sel,
    input  logic                 EntradaValid,
    output logic                 EntradaReady,
    output logic [WIDTH-1:0]     SalidaA,
    output logic [WIDTH-1:0]     SalidaB,
    output logic [WIDTH-1:0]     SalidaC,
    output logic                 ValidA,
    output logic                 ValidB,
    output logic                 ValidC,
    input  logic                 ReadyA,
    input  logic                 ReadyB,
    input  logic                 ReadyC,
    output logic                 Error,
    output logic [CNT_WIDTH-1:0] DropCount
);

    localparam logic [1:0] SEL_A    = 2'd2;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_C    = 2'd0;
    localparam logic [1:0] SEL_DROP = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic take_a;
    logic take_b;
    logic take_c;
    logic fire;
    logic load_a;
    logic load_b;
    logic load_c;
    logic drop;

    // A channel can take a word when empty, or when its current word leaves this cycle.
    assign take_a = ~ValidA | ReadyA;
    assign take_b = ~ValidB | ReadyB;
    assign take_c = ~ValidC | ReadyC;

    always_comb begin
        EntradaReady = 1'b1;
        case (Sel)
            SEL_A:   EntradaReady = take_a;
            SEL_B:   EntradaReady = take_b;
            SEL_C:   EntradaReady = take_c;
            default: EntradaReady = 1'b1;
        endcase
    end

    assign fire   = EntradaValid & EntradaReady;
    assign load_a = fire & (Sel == SEL_A);
    assign load_b = fire & (Sel == SEL_B);
    assign load_c = fire & (Sel == SEL_C);
    assign drop   = fire & (Sel == SEL_DROP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SalidaA <= '0;
            ValidA  <= 1'b0;
        end else if (load_a) begin
            SalidaA <= Entrada;
            ValidA  <= 1'b1;
        end else if (ReadyA) begin
            ValidA  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SalidaB <= '0;
            ValidB  <= 1'b0;
        end else if (load_b) begin
            SalidaB <= Entrada;
            ValidB  <= 1'b1;
        end else if (ReadyB) begin
            ValidB  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SalidaC <= '0;
            ValidC  <= 1'b0;
        end else if (load_c) begin
            SalidaC <= Entrada;
            ValidC  <= 1'b1;
        end else if (ReadyC) begin
            ValidC  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Error     <= 1'b0;
            DropCount <= '0;
        end else if (drop) begin
            Error <= 1'b1;
            if (DropCount != CNT_MAX) begin
                DropCount <= DropCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_demultiplexor_1in_3out.sv
// Scoreboard bench: stimulus pushes expected words per channel, a negedge monitor
// pops and compares them on every consumer handshake.
module tb_demultiplexor_1in_3out;

    logic        clk;
    logic        rst_n;
    logic [15:0] Entrada;
    logic [1:0]  Sel;
    logic        EntradaValid;
    logic        EntradaReady;
    logic [15:0] SalidaA, SalidaB, SalidaC;
    logic        ValidA, ValidB, ValidC;
    logic        ReadyA, ReadyB, ReadyC;
    logic        Error;
    logic [7:0]  DropCount;

    logic [15:0] Entrada2;
    logic [1:0]  Sel2;
    logic        EntradaValid2;
    logic        EntradaReady2;
    logic [15:0] SalidaA2, SalidaB2, SalidaC2;
    logic        ValidA2, ValidB2, ValidC2;
    logic        Error2;
    logic [1:0]  DropCount2;

    int checks   = 0;
    int failures = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] qc[$];

    demultiplexor_1in_3out #(.WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .Entrada(Entrada), .Sel(Sel),
        .EntradaValid(EntradaValid), .EntradaReady(EntradaReady),
        .SalidaA(SalidaA), .SalidaB(SalidaB), .SalidaC(SalidaC),
        .ValidA(ValidA), .ValidB(ValidB), .ValidC(ValidC),
        .ReadyA(ReadyA), .ReadyB(ReadyB), .ReadyC(ReadyC),
        .Error(Error), .DropCount(DropCount)
    );

    demultiplexor_1in_3out #(.WIDTH(16), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Entrada(Entrada2), .Sel(Sel2),
        .EntradaValid(EntradaValid2), .EntradaReady(EntradaReady2),
        .SalidaA(SalidaA2), .SalidaB(SalidaB2), .SalidaC(SalidaC2),
        .ValidA(ValidA2), .ValidB(ValidB2), .ValidC(ValidC2),
        .ReadyA(1'b1), .ReadyB(1'b1), .ReadyC(1'b1),
        .Error(Error2), .DropCount(DropCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Handshakes happen at the next posedge; inputs are stable from posedge+1.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ValidA && ReadyA) begin
                if (qa.size() == 0) check("unexpected_A", {16'h0, SalidaA}, 32'hFFFF_FFFF);
                else check("word_A", {16'h0, SalidaA}, {16'h0, qa.pop_front()});
            end
            if (ValidB && ReadyB) begin
                if (qb.size() == 0) check("unexpected_B", {16'h0, SalidaB}, 32'hFFFF_FFFF);
                else check("word_B", {16'h0, SalidaB}, {16'h0, qb.pop_front()});
            end
            if (ValidC && ReadyC) begin
                if (qc.size() == 0) check("unexpected_C", {16'h0, SalidaC}, 32'hFFFF_FFFF);
                else check("word_C", {16'h0, SalidaC}, {16'h0, qc.pop_front()});
            end
        end
    end

    // One cycle: drive inputs, check ready and {ValidA,ValidB,ValidC}, record accepted word.
    task automatic step(input logic [15:0] data, input logic [1:0] sel, input logic vld,
                        input logic [2:0] rdys, input logic exp_rdy, input logic [2:0] exp_v);
        @(posedge clk);
        #1;
        Entrada = data;
        Sel = sel;
        EntradaValid = vld;
        {ReadyA, ReadyB, ReadyC} = rdys;
        @(negedge clk);
        check("entrada_ready", {31'h0, EntradaReady}, {31'h0, exp_rdy});
        check("valids", {29'h0, ValidA, ValidB, ValidC}, {29'h0, exp_v});
        if (vld && exp_rdy) begin
            case (sel)
                2'd2: qa.push_back(data);
                2'd1: qb.push_back(data);
                2'd0: qc.push_back(data);
                default: ;
            endcase
        end
    endtask

    initial begin
        rst_n = 1'b0;
        Entrada = '0;
        Sel = 2'd0;
        EntradaValid = 1'b0;
        {ReadyA, ReadyB, ReadyC} = 3'b000;
        Entrada2 = 16'h0;
        Sel2 = 2'd3;
        EntradaValid2 = 1'b0;

        #2;
        check("rst_valids", {29'h0, ValidA, ValidB, ValidC}, 32'h0);
        check("rst_salidas", {SalidaA, SalidaB}, 32'h0);
        check("rst_salidaC", {16'h0, SalidaC}, 32'h0);
        check("rst_error_cnt", {23'h0, Error, DropCount}, 32'h0);
        check("rst_ready_selC", {31'h0, EntradaReady}, 32'h1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // basic routing, all consumers ready
        step(16'h1111, 2'd2, 1'b1, 3'b111, 1'b1, 3'b000);
        step(16'h2222, 2'd1, 1'b1, 3'b111, 1'b1, 3'b100);
        step(16'h3333, 2'd0, 1'b1, 3'b111, 1'b1, 3'b010);
        step(16'h0000, 2'd0, 1'b0, 3'b111, 1'b1, 3'b001);
        step(16'h0000, 2'd0, 1'b0, 3'b111, 1'b1, 3'b000);

        // backpressure on A
        step(16'hAAAA, 2'd2, 1'b1, 3'b011, 1'b1, 3'b000);
        step(16'hBBBB, 2'd2, 1'b1, 3'b011, 1'b0, 3'b100);
        check("hold_A_1", {16'h0, SalidaA}, 32'h0000_AAAA);
        step(16'hBBBB, 2'd2, 1'b1, 3'b011, 1'b0, 3'b100);
        check("hold_A_2", {16'h0, SalidaA}, 32'h0000_AAAA);
        step(16'hBBBB, 2'd2, 1'b1, 3'b111, 1'b1, 3'b100);
        step(16'h0000, 2'd2, 1'b0, 3'b011, 1'b0, 3'b100);
        check("passthru_A", {16'h0, SalidaA}, 32'h0000_BBBB);

        // channel independence while A is blocked
        step(16'h0C0C, 2'd0, 1'b1, 3'b011, 1'b1, 3'b100);
        step(16'h0000, 2'd0, 1'b0, 3'b011, 1'b1, 3'b101);
        check("indep_C", {16'h0, SalidaC}, 32'h0000_0C0C);
        check("indep_A", {16'h0, SalidaA}, 32'h0000_BBBB);
        step(16'h0000, 2'd0, 1'b0, 3'b011, 1'b1, 3'b100);

        // invalid select drops
        check("no_error_yet", {23'h0, Error, DropCount}, 32'h0);
        step(16'h5555, 2'd3, 1'b1, 3'b011, 1'b1, 3'b100);
        step(16'h5555, 2'd3, 1'b1, 3'b011, 1'b1, 3'b100);
        step(16'h5555, 2'd3, 1'b1, 3'b011, 1'b1, 3'b100);
        step(16'h0000, 2'd0, 1'b0, 3'b011, 1'b1, 3'b100);
        check("drop_error", {31'h0, Error}, 32'h1);
        check("drop_count", {24'h0, DropCount}, 32'h3);
        check("drop_keeps_A", {16'h0, SalidaA}, 32'h0000_BBBB);

        // fill B too, then asynchronous reset between edges
        step(16'h1234, 2'd1, 1'b1, 3'b000, 1'b1, 3'b100);
        step(16'h0000, 2'd0, 1'b0, 3'b000, 1'b1, 3'b110);
        #1 rst_n = 1'b0;
        #1;
        check("async_valids", {29'h0, ValidA, ValidB, ValidC}, 32'h0);
        check("async_salidas", {SalidaA, SalidaB}, 32'h0);
        check("async_error_cnt", {23'h0, Error, DropCount}, 32'h0);
        qa.delete();
        qb.delete();
        qc.delete();
        #1 rst_n = 1'b1;
        step(16'h7777, 2'd2, 1'b1, 3'b111, 1'b1, 3'b000);
        step(16'h0000, 2'd0, 1'b0, 3'b111, 1'b1, 3'b100);
        step(16'h0000, 2'd0, 1'b0, 3'b111, 1'b1, 3'b000);

        // saturation of a 2-bit drop counter
        @(posedge clk);
        #1 EntradaValid2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sat_cnt_3", {30'h0, DropCount2}, 32'h3);
        repeat (2) @(posedge clk);
        #1 EntradaValid2 = 1'b0;
        @(negedge clk);
        check("sat_cnt_5", {30'h0, DropCount2}, 32'h3);
        check("sat_error", {31'h0, Error2}, 32'h1);
        check("sat_no_valid", {29'h0, ValidA2, ValidB2, ValidC2}, 32'h0);

        check("queues_drained", qa.size() + qb.size() + qc.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demultiplexor_1in_3out.md
DEMULTIPLEXOR_1IN_3OUT -- requirements
Module: demultiplexor_1in_3out

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data word width in bits.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 8, giving the drop-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Entrada  input  WIDTH  data word to route.
REQ-006 Sel  input  2  destination select: 2 routes to A, 1 routes to B, 0 routes to C, 3 is invalid.
REQ-007 EntradaValid  input  1  Entrada/Sel valid this cycle.
REQ-008 EntradaReady  output  1  word accepted when EntradaValid and EntradaReady are both high on a clk edge.
REQ-009 SalidaA, SalidaB, SalidaC  output  WIDTH each  registered output words.
REQ-010 ValidA, ValidB, ValidC  output  1 each  the matching Salida holds an undelivered word.
REQ-011 ReadyA, ReadyB, ReadyC  input  1 each  the consumer takes the word when ValidX and ReadyX are both high on a clk edge.
REQ-012 Error  output  1  sticky flag: at least one word accepted with Sel==3.
REQ-013 DropCount  output  CNT_WIDTH  count of words accepted with Sel==3, saturating.

Function
REQ-014 Each channel X (A/B/C) SHALL be a one-entry holding register with flag ValidX; SalidaX SHALL come straight from that register, with no combinational path from Entrada.
REQ-015 Channel X SHALL be able to accept a word when ValidX==0, or when ValidX==1 and ReadyX==1 in the same cycle (pass-through).
REQ-016 EntradaReady SHALL be combinational: 1 when Sel==3; otherwise equal to the accept condition of the channel that Sel selects.
REQ-017 EntradaReady SHALL NOT depend on EntradaValid.
REQ-018 On an accepted word with Sel in {0,1,2}, the selected SalidaX SHALL load Entrada and ValidX SHALL be 1 on the next cycle (latency 1 clock).
REQ-019 Unselected channels SHALL hold their data and flags, except where a consumer handshake clears them.
REQ-020 On a consumer handshake (ValidX and ReadyX) with no new load into X, ValidX SHALL go to 0 on the next cycle; SalidaX SHALL keep its last value.
REQ-021 A consumer handshake and a load into the same channel in the same cycle: ValidX SHALL stay 1, SalidaX SHALL take the new word, and no word SHALL be lost or duplicated.
REQ-022 ReadyX while ValidX==0 SHALL have no effect.
REQ-023 A word accepted with Sel==3 SHALL be discarded: no channel changes, Error is set to 1, and DropCount increments by 1.
REQ-024 DropCount SHALL saturate at 2^CNT_WIDTH-1 and not wrap.
REQ-025 Error SHALL stay set until reset.
REQ-026 While ValidX==1, SalidaX SHALL stay stable until the consumer handshake.
REQ-027 Once ValidX is 1 it SHALL stay 1 until the consumer handshake.
REQ-028 Channels SHALL be independent: backpressure on one channel SHALL NOT stall words to other channels (per-word Sel, in-order per channel only).
REQ-029 Throughput SHALL be one word per clock when the target consumer holds ReadyX high.

Reset
REQ-030 While rst_n==0, and immediately on its falling edge: ValidA/B/C=0, SalidaA/B/C=0, Error=0, DropCount=0.
REQ-031 During reset EntradaReady SHALL still follow REQ-016 using the cleared flags, but no word SHALL be accepted.
REQ-032 A reset in mid-operation SHALL discard all buffered words.
REQ-033 The first accept SHALL be possible on the first rising clk edge after rst_n returns to 1.

Verification
REQ-034 Basic routing: after reset, send 16'h1111/Sel=2, 16'h2222/Sel=1, 16'h3333/Sel=0 on consecutive cycles with all Ready=1 -> SalidaA=1111, SalidaB=2222, SalidaC=3333, each Valid high for exactly one cycle, 1 clock after its accept.
REQ-035 Backpressure: ReadyA=0, send 16'hAAAA then 16'hBBBB, both Sel=2 -> first accepted; EntradaReady=0 with Sel=2 while held; SalidaA=AAAA stable; raise ReadyA -> BBBB loaded in the same cycle AAAA is taken, ValidA stays 1.
REQ-036 Channel independence: channel A blocked (ValidA=1, ReadyA=0), send 16'h0C0C with Sel=0 -> EntradaReady=1, SalidaC=0C0C next cycle, channel A unchanged.
REQ-037 Invalid select: 3 words with Sel=3 -> EntradaReady=1, no Valid asserted, Error=1, DropCount=3. With CNT_WIDTH=2, 5 drops -> DropCount=3.
REQ-038 Reset mid-operation: ValidA=ValidB=1 and Error=1, pulse rst_n low between clk edges -> all outputs 0 immediately (asynchronous); the next word after release routes normally.
